param_conv_core: RTL

- Streaming 2-D convolution engine for the next-generation convolver.
- Accepts one column of K samples per handshake and keeps a sliding K x K window.
- Multiplies the window by a programmable K x K coefficient bank through a 3-stage pipeline, then queues results in an internal FIFO with valid/ready output.
- Sits behind the bus slave: the slave drives columns and coefficients and drains results. Adds generic kernel size, stride-1 continuous output, saturation mode and backpressure.

---
 rtl/param_conv_core_if.sv | 32 +++
 rtl/param_conv_core.sv | 129 ++++++++++++
 2 files changed

// File: rtl/param_conv_core_if.sv
// Column/coefficient/result handshake bundle between the bus slave and the convolution core.
interface param_conv_core_if #(
  parameter int K          = 3,
  parameter int DW         = 8,
  parameter int CW         = 8,
  parameter int RW         = 16,
  parameter int FIFO_DEPTH = 8
);
  logic                          coeff_wr;
  logic [$clog2(K*K)-1:0]        coeff_idx;
  logic signed [CW-1:0]          coeff_data;
  logic                          col_valid;
  logic                          col_ready;
  logic [K*DW-1:0]               col_data;
  logic                          new_row;
  logic                          sat_en;
  logic                          res_valid;
  logic                          res_ready;
  logic [RW-1:0]                 res_data;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count;
  logic                          busy;

  modport master (
    output coeff_wr, coeff_idx, coeff_data, col_valid, col_data, new_row, sat_en, res_ready,
    input  col_ready, res_valid, res_data, fifo_count, busy
  );

  modport slave (
    input  coeff_wr, coeff_idx, coeff_data, col_valid, col_data, new_row, sat_en, res_ready,
    output col_ready, res_valid, res_data, fifo_count, busy
  );
endinterface

// File: rtl/param_conv_core.sv
// Streaming K x K convolution: sliding column window, 3-stage multiply/sum/reduce pipeline,
// result FIFO; col_ready reserves FIFO space for every in-flight result so nothing is dropped.
module param_conv_core #(
  parameter int K          = 3,
  parameter int DW         = 8,
  parameter int CW         = 8,
  parameter int RW         = 16,
  parameter int FIFO_DEPTH = 8
) (
  input logic              clk,
  input logic              rst,
  param_conv_core_if.slave bus
);
  localparam int NC  = K * K;
  localparam int PW  = DW + CW;
  localparam int SW  = PW + $clog2(NC);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CNW = $clog2(K + 1);
  localparam logic signed [SW-1:0] RMAX = {{(SW-RW+1){1'b0}}, {(RW-1){1'b1}}};
  localparam logic signed [SW-1:0] RMIN = {{(SW-RW+1){1'b1}}, {(RW-1){1'b0}}};

  logic [K*DW-1:0]      win_q   [K];
  logic signed [CW-1:0] coeff_q [NC];
  logic [CNW-1:0]       cnt_q, cnt_d;
  logic                 v0_q, v1_q, v2_q;
  logic                 s0_q, s1_q, s2_q;
  logic signed [PW-1:0] prod_q [NC];
  logic signed [PW-1:0] prod_d [NC];
  logic signed [SW-1:0] sum_q, sum_d;
  logic [RW-1:0]        red_d;
  logic [RW-1:0]        mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wp_q, rp_q;
  logic [AW:0]          fcnt_q, fcnt_d;
  logic [AW+1:0]        occ;
  logic                 accept, fire, push, pop;

  // Occupancy counts results already queued plus every valid stage that will land in the FIFO.
  assign occ           = (AW+2)'(fcnt_q) + (AW+2)'(v0_q) + (AW+2)'(v1_q) + (AW+2)'(v2_q);
  assign bus.col_ready = !rst && (occ < (AW+2)'(FIFO_DEPTH));
  assign accept        = bus.col_valid && bus.col_ready;
  assign fire          = accept && (cnt_d == CNW'(K));
  assign push          = v2_q;
  assign pop           = bus.res_valid && bus.res_ready;

  assign bus.res_valid  = (fcnt_q != '0);
  assign bus.res_data   = mem_q[rp_q];
  assign bus.fifo_count = fcnt_q;
  assign bus.busy       = v0_q || v1_q || v2_q;

  always_comb begin
    cnt_d = cnt_q;
    if (bus.new_row)              cnt_d = CNW'(1);
    else if (cnt_q != CNW'(K))    cnt_d = cnt_q + CNW'(1);
  end

  always_comb begin
    prod_d = '{default: '0};
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) begin
        prod_d[r*K+c] = PW'($signed(win_q[c][r*DW +: DW])) * PW'(coeff_q[r*K+c]);
      end
    end
  end

  always_comb begin
    sum_d = '0;
    for (int i = 0; i < NC; i++) sum_d = sum_d + SW'(prod_q[i]);
  end

  always_comb begin
    red_d = sum_q[RW-1:0];
    if (s2_q) begin
      if (sum_q > RMAX)      red_d = RMAX[RW-1:0];
      else if (sum_q < RMIN) red_d = RMIN[RW-1:0];
    end
  end

  always_comb begin
    fcnt_d = fcnt_q;
    case ({push, pop})
      2'b10:   fcnt_d = fcnt_q + (AW+1)'(1);
      2'b01:   fcnt_d = fcnt_q - (AW+1)'(1);
      default: fcnt_d = fcnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < K; c++) win_q[c] <= '0;
      for (int i = 0; i < NC; i++) begin
        coeff_q[i] <= '0;
        prod_q[i]  <= '0;
      end
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      cnt_q  <= '0;
      v0_q   <= 1'b0;
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      s0_q   <= 1'b0;
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      sum_q  <= '0;
      wp_q   <= '0;
      rp_q   <= '0;
      fcnt_q <= '0;
    end else begin
      if (accept) begin
        for (int c = 0; c < K-1; c++) win_q[c] <= win_q[c+1];
        win_q[K-1] <= bus.col_data;
        cnt_q      <= cnt_d;
      end
      if (bus.coeff_wr && (int'(bus.coeff_idx) < NC)) coeff_q[bus.coeff_idx] <= bus.coeff_data;
      v0_q   <= fire;
      s0_q   <= bus.sat_en;
      v1_q   <= v0_q;
      s1_q   <= s0_q;
      prod_q <= prod_d;
      v2_q   <= v1_q;
      s2_q   <= s1_q;
      sum_q  <= sum_d;
      if (push) begin
        mem_q[wp_q] <= red_d;
        wp_q        <= wp_q + AW'(1);
      end
      if (pop) rp_q <= rp_q + AW'(1);
      fcnt_q <= fcnt_d;
    end
  end
endmodule
